// File: rtl/hw_port_pkg.sv
// Shared types and control-word layout for the to_hw_port frame latch.
// The control word is the tenth Nios export; the parameter words are fixed 32 bits.
package hw_port_pkg;

  localparam int WORD_W  = 32;

  localparam int SEQ_LSB = 0;
  localparam int SEQ_MSB = 7;
  localparam int EN_BIT  = 8;
  localparam int IMM_BIT = 9;
  localparam int CLR_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ARMED  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  typedef struct packed {
    logic        soft_clear;
    logic [20:0] rsvd;
    logic        immediate;
    logic        enable;
    logic [7:0]  seq;
  } ctrl_t;

  function automatic ctrl_t unpack_ctrl(input logic [WORD_W-1:0] w);
    ctrl_t c;
    c.seq        = w[SEQ_MSB:SEQ_LSB];
    c.enable     = w[EN_BIT];
    c.immediate  = w[IMM_BIT];
    c.rsvd       = w[CLR_BIT-1:IMM_BIT+1];
    c.soft_clear = w[CLR_BIT];
    return c;
  endfunction

endpackage

// File: rtl/hw_port_frame_latch_sat_counter8.sv
// 8-bit saturating event counter with synchronous reset and clear.
// Clear wins over increment; the count holds at 255 once reached.
module sat_counter8 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [7:0] cnt_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= 8'd0;
    end else if (inc_i && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hw_port_frame_latch.sv
// Snapshots the nine Nios parameter words on each new sequence number and commits
// them atomically at the next VGA frame boundary (or at once in immediate mode).
module hw_port_frame_latch
  import hw_port_pkg::*;
#(
  parameter int N_WORDS    = 9,
  parameter int SETTLE_CYC = 2
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [N_WORDS*WORD_W-1:0] param_in,
  input  logic [WORD_W-1:0]         ctrl_in,
  input  logic                      frame_start,
  output logic [N_WORDS*WORD_W-1:0] param_out,
  output logic                      commit_pulse,
  output logic [7:0]                ack_seq,
  output logic                      busy,
  output logic [7:0]                overrun_cnt
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC - 1);

  ctrl_t                      ctrl_q;
  state_e                     state_q;
  logic [3:0]                 settle_cnt_q;
  logic [7:0]                 last_seq_q;
  logic [7:0]                 pend_seq_q;
  logic [7:0]                 ack_seq_q;
  logic [N_WORDS*WORD_W-1:0]  shadow_q;
  logic [N_WORDS*WORD_W-1:0]  param_out_q;
  logic                       commit_pulse_q;
  logic                       busy_q;

  logic                       new_req;
  logic                       ovr_inc;
  logic                       unused_rsvd;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= unpack_ctrl(ctrl_in);
    end
  end

  assign unused_rsvd = ^ctrl_q.rsvd;

  // Sequence numbers are compared for change only, so 255 -> 0 is just another new set.
  assign new_req = ctrl_q.enable && (ctrl_q.seq != last_seq_q);

  // A set is superseded when a new request lands before the pending one commits;
  // in ARMED a simultaneous frame_start lets the old set through instead.
  assign ovr_inc = !ctrl_q.soft_clear && new_req &&
                   ((state_q == ST_SETTLE) || ((state_q == ST_ARMED) && !frame_start));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      settle_cnt_q   <= 4'd0;
      last_seq_q     <= 8'd0;
      pend_seq_q     <= 8'd0;
      ack_seq_q      <= 8'd0;
      shadow_q       <= '0;
      param_out_q    <= '0;
      commit_pulse_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      commit_pulse_q <= 1'b0;
      if (ctrl_q.soft_clear) begin
        // ack_seq is deliberately kept so software can still see the last handshake.
        state_q     <= ST_IDLE;
        busy_q      <= 1'b0;
        shadow_q    <= '0;
        param_out_q <= '0;
        last_seq_q  <= 8'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (new_req) begin
              state_q      <= ST_SETTLE;
              busy_q       <= 1'b1;
              settle_cnt_q <= SETTLE_INIT;
              last_seq_q   <= ctrl_q.seq;
            end
          end
          ST_SETTLE: begin
            if (new_req) begin
              settle_cnt_q <= SETTLE_INIT;
              last_seq_q   <= ctrl_q.seq;
            end else if (settle_cnt_q == 4'd0) begin
              shadow_q   <= param_in;
              pend_seq_q <= last_seq_q;
              if (ctrl_q.immediate) begin
                state_q <= ST_COMMIT;
                busy_q  <= 1'b0;
              end else begin
                state_q <= ST_ARMED;
              end
            end else begin
              settle_cnt_q <= settle_cnt_q - 4'd1;
            end
          end
          ST_ARMED: begin
            if (frame_start) begin
              state_q <= ST_COMMIT;
              busy_q  <= 1'b0;
            end else if (new_req) begin
              state_q      <= ST_SETTLE;
              settle_cnt_q <= SETTLE_INIT;
              last_seq_q   <= ctrl_q.seq;
            end
          end
          ST_COMMIT: begin
            param_out_q    <= shadow_q;
            ack_seq_q      <= pend_seq_q;
            commit_pulse_q <= 1'b1;
            state_q        <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter8 u_overrun (
    .clk_i (Clk),
    .rst_i (Reset),
    .clr_i (ctrl_q.soft_clear),
    .inc_i (ovr_inc),
    .cnt_o (overrun_cnt)
  );

  assign param_out    = param_out_q;
  assign commit_pulse = commit_pulse_q;
  assign ack_seq      = ack_seq_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_hw_port_frame_latch.sv
// Scoreboard bench for hw_port_frame_latch: expected commits are queued as stimulus
// is driven and popped whenever commit_pulse is seen.
module tb_hw_port_frame_latch;

  localparam int NW = 9;
  localparam int PW = NW * 32;

  typedef struct packed {
    logic [PW-1:0] p;
    logic [7:0]    s;
  } exp_t;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [PW-1:0] param_in;
  logic [31:0]   ctrl_in;
  logic          frame_start;
  logic [PW-1:0] param_out;
  logic          commit_pulse;
  logic [7:0]    ack_seq;
  logic          busy;
  logic [7:0]    overrun_cnt;

  exp_t sb[$];
  int   vectors = 0;
  int   errors = 0;
  int   ncommit = 0;
  int   exp_commits = 0;
  logic prev_pulse = 1'b0;

  hw_port_frame_latch #(.N_WORDS(NW), .SETTLE_CYC(2)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .param_in     (param_in),
    .ctrl_in      (ctrl_in),
    .frame_start  (frame_start),
    .param_out    (param_out),
    .commit_pulse (commit_pulse),
    .ack_seq      (ack_seq),
    .busy         (busy),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] make_params(input logic [31:0] base);
    logic [PW-1:0] v;
    for (int i = 0; i < NW; i++) v[i*32 +: 32] = base + 32'(i);
    return v;
  endfunction

  task automatic set_ctrl(input logic [7:0] seq, input logic en, input logic imm, input logic clr);
    @(posedge Clk);
    #1;
    ctrl_in = {clr, 21'd0, imm, en, seq};
  endtask

  task automatic push_exp(input logic [PW-1:0] p, input logic [7:0] s);
    exp_t e;
    e.p = p;
    e.s = s;
    sb.push_back(e);
    exp_commits++;
  endtask

  task automatic pulse_frame();
    @(posedge Clk);
    #1 frame_start = 1'b1;
    @(posedge Clk);
    #1 frame_start = 1'b0;
  endtask

  task automatic wait_commit(input int budget);
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if (commit_pulse === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) check("commit_timeout", 0, 1);
  endtask

  // Scoreboard consumer
  always @(negedge Clk) begin
    if (commit_pulse === 1'b1) begin
      ncommit++;
      if (prev_pulse) check("pulse_width", 2, 1);
      if (sb.size() == 0) begin
        check("unexpected_commit", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("commit_params", param_out, e.p);
        check("commit_ack", PW'(ack_seq), PW'(e.s));
      end
    end
    prev_pulse = (commit_pulse === 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] p_a, p_b, p_c, p_d, p_first;

    Reset = 1'b1;
    ctrl_in = 32'd0;
    param_in = '0;
    frame_start = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_param_out", param_out, '0);
    check("rst_pulse", PW'(commit_pulse), 0);
    check("rst_ack", PW'(ack_seq), 0);
    check("rst_busy", PW'(busy), 0);
    check("rst_overrun", PW'(overrun_cnt), 0);
    @(posedge Clk);
    #1 Reset = 1'b0;

    // Immediate mode: commit_pulse visible in the cycle after E4
    p_first = '0;
    p_first[31:0] = 32'hDEADBEEF;
    param_in = p_first;
    push_exp(p_first, 8'd1);
    set_ctrl(8'd1, 1'b1, 1'b1, 1'b0);
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    check("imm_before_E4", PW'(commit_pulse), 0);
    @(posedge Clk);
    @(negedge Clk);
    check("imm_pulse_E4", PW'(commit_pulse), 1);
    check("imm_word0", PW'(param_out[31:0]), PW'(32'hDEADBEEF));
    check("imm_ack", PW'(ack_seq), 1);

    // Frame mode
    param_in = make_params(32'h100);
    push_exp(make_params(32'h100), 8'd2);
    set_ctrl(8'd2, 1'b1, 1'b0, 1'b0);
    repeat (8) @(posedge Clk);
    @(negedge Clk);
    check("frame_busy_armed", PW'(busy), 1);
    check("frame_out_held", param_out, p_first);
    pulse_frame();
    @(negedge Clk);
    check("frame_pulse_F", PW'(commit_pulse), 0);
    @(posedge Clk);
    @(negedge Clk);
    check("frame_pulse_F1", PW'(commit_pulse), 1);
    check("frame_ack", PW'(ack_seq), 2);
    @(negedge Clk);
    check("frame_pulse_off", PW'(commit_pulse), 0);
    check("frame_busy_idle", PW'(busy), 0);

    // Overrun: seq 3 superseded by seq 4 before a frame arrives
    p_a = make_params(32'hA000);
    p_b = make_params(32'hB000);
    param_in = p_a;
    set_ctrl(8'd3, 1'b1, 1'b0, 1'b0);
    repeat (6) @(posedge Clk);
    #1 param_in = p_b;
    push_exp(p_b, 8'd4);
    set_ctrl(8'd4, 1'b1, 1'b0, 1'b0);
    repeat (6) @(posedge Clk);
    @(negedge Clk);
    check("overrun_one", PW'(overrun_cnt), 1);
    pulse_frame();
    wait_commit(20);
    check("overrun_ack", PW'(ack_seq), 4);

    // 300 supersessions saturate the counter
    for (int i = 0; i < 300; i++) begin
      set_ctrl(8'(20 + i), 1'b1, 1'b0, 1'b0);
      @(posedge Clk);
    end
    repeat (6) @(posedge Clk);
    @(negedge Clk);
    check("overrun_sat", PW'(overrun_cnt), 255);
    check("sat_busy_armed", PW'(busy), 1);

    // soft_clear while ARMED: no commit, outputs cleared, ack kept
    set_ctrl(8'd0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("clr_param_out", param_out, '0);
    check("clr_overrun", PW'(overrun_cnt), 0);
    check("clr_ack_kept", PW'(ack_seq), 4);
    check("clr_busy", PW'(busy), 0);
    set_ctrl(8'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge Clk);

    // Collision: frame_start and seq 5 arrive together while seq 4 is ARMED
    p_c = make_params(32'hC000);
    p_d = make_params(32'hD000);
    param_in = p_c;
    push_exp(p_c, 8'd4);
    set_ctrl(8'd4, 1'b1, 1'b0, 1'b0);
    repeat (6) @(posedge Clk);
    #1;
    param_in = p_d;
    ctrl_in = {1'b0, 21'd0, 1'b0, 1'b1, 8'd5};
    push_exp(p_d, 8'd5);
    @(posedge Clk);
    #1 frame_start = 1'b1;
    @(posedge Clk);
    #1 frame_start = 1'b0;
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1 frame_start = 1'b1;
    @(posedge Clk);
    #1 frame_start = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    check("coll_busy_armed", PW'(busy), 1);
    check("coll_ack_first", PW'(ack_seq), 4);
    pulse_frame();
    wait_commit(20);
    check("coll_ack_second", PW'(ack_seq), 5);

    // Wrap 255 -> 0 is a new sequence
    param_in = make_params(32'hE000);
    push_exp(make_params(32'hE000), 8'd255);
    set_ctrl(8'd255, 1'b1, 1'b1, 1'b0);
    wait_commit(20);
    param_in = make_params(32'hF000);
    push_exp(make_params(32'hF000), 8'd0);
    set_ctrl(8'd0, 1'b1, 1'b1, 1'b0);
    wait_commit(20);
    check("wrap_ack", PW'(ack_seq), 0);

    // enable=0 with a seq change does nothing
    param_in = make_params(32'h7000);
    set_ctrl(8'd7, 1'b0, 1'b1, 1'b0);
    repeat (8) @(posedge Clk);
    @(negedge Clk);
    check("dis_busy", PW'(busy), 0);
    check("dis_ack", PW'(ack_seq), 0);
    check("dis_params", param_out, make_params(32'hF000));

    // Reset while ARMED discards the pending set
    set_ctrl(8'd9, 1'b1, 1'b0, 1'b0);
    repeat (6) @(posedge Clk);
    @(negedge Clk);
    check("rstarm_busy", PW'(busy), 1);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    ctrl_in = 32'd0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    pulse_frame();
    repeat (5) @(negedge Clk);
    check("rstarm_param_out", param_out, '0);
    check("rstarm_ack", PW'(ack_seq), 0);
    check("rstarm_busy_idle", PW'(busy), 0);

    check("sb_drained", PW'(sb.size()), 0);
    check("commit_count", PW'(ncommit), PW'(exp_commits));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
